// File: rtl/ahb_burst_master_pkg.sv
// ==================================================================
// Definitions: shared AHB-Lite types and constants for ahb_burst_master (rev 1.0)
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

package Definitions;

  localparam int ADDRWIDTH = 32;
  localparam int DATAWIDTH = 32;
  localparam logic [2:0] DATATRANFER_SIZE = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } Trans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } BType_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } Response_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_LAST  = 3'd3,
    ST_ERR   = 3'd4
  } Mst_State_t;

  // INCR length is clamped to 1..16 so the 4-bit beat index never overflows.
  function automatic logic [4:0] burst_beats(input BType_t burst, input logic [4:0] len);
    case (burst)
      INCR:           burst_beats = (len == 5'd0) ? 5'd1 : ((len > 5'd16) ? 5'd16 : len);
      WRAP4, INCR4:   burst_beats = 5'd4;
      WRAP8, INCR8:   burst_beats = 5'd8;
      WRAP16, INCR16: burst_beats = 5'd16;
      default:        burst_beats = 5'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_burst_master_addr_gen.sv
// ==================================================================
// ahb_addr_gen: byte-step next-address for INCR/WRAP bursts (rev 1.0)
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

module ahb_addr_gen
  import Definitions::*;
(
  input  logic [ADDRWIDTH-1:0] base,
  input  logic [3:0]           beat,
  input  BType_t               burst,
  output logic [ADDRWIDTH-1:0] addr
);

  logic [ADDRWIDTH-1:0] lin;

  // Wrapping bursts keep the upper bits of the first address and wrap the low bits.
  always_comb begin
    lin = base + {{(ADDRWIDTH-4){1'b0}}, beat};
    case (burst)
      WRAP4:   addr = {base[ADDRWIDTH-1:2], lin[1:0]};
      WRAP8:   addr = {base[ADDRWIDTH-1:3], lin[2:0]};
      WRAP16:  addr = {base[ADDRWIDTH-1:4], lin[3:0]};
      default: addr = lin;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_burst_master.sv
// ==================================================================
// ahb_burst_master: AHB-Lite byte-burst master, NONSEQ/SEQ sequencing (rev 1.0)
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

module ahb_burst_master
  import Definitions::*;
(
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  BType_t               cmd_burst,
  input  logic [4:0]           cmd_len,
  input  logic [7:0]           wr_data,
  output logic                 wr_pop,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 error,
  output logic [ADDRWIDTH-1:0] HADDR,
  output Trans_t               HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output BType_t               HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  input  Response_t            HRESP,
  input  logic [DATAWIDTH-1:0] HRDATA
);

  Mst_State_t           state_q, state_d;
  logic [ADDRWIDTH-1:0] haddr_q, haddr_d, base_q, base_d, next_addr;
  Trans_t               htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  BType_t               hburst_q, hburst_d;
  logic [DATAWIDTH-1:0] hwdata_q, hwdata_d;
  logic [3:0]           beat_q, beat_d;
  logic [4:0]           beats_q, beats_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d, done_q, done_d, error_q, error_d;
  logic                 last_beat, err_first, rd_capture;
  logic                 unused_hrdata;

  ahb_addr_gen u_addr_gen (
    .base  (base_q),
    .beat  (beat_q + 4'd1),
    .burst (hburst_q),
    .addr  (next_addr)
  );

  assign last_beat     = ({1'b0, beat_q} == (beats_q - 5'd1));
  assign err_first     = (HRESP == ERROR) && !HREADY;
  assign rd_capture    = HREADY && (HRESP == OKAY) && !hwrite_q;
  assign unused_hrdata = ^HRDATA[DATAWIDTH-1:8];

  // ST_BURST and ST_LAST are the only states with a data phase in flight.
  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    base_d     = base_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    beat_d     = beat_q;
    beats_d    = beats_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    wr_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d   = cmd_addr;
          haddr_d  = cmd_addr;
          htrans_d = NONSEQ;
          hwrite_d = cmd_write;
          hburst_d = cmd_burst;
          beats_d  = burst_beats(cmd_burst, cmd_len);
          beat_d   = 4'd0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          wr_pop = hwrite_q;
          if (hwrite_q) hwdata_d = {{(DATAWIDTH-8){1'b0}}, wr_data};
          if (beats_q > 5'd1) begin
            beat_d   = beat_q + 4'd1;
            haddr_d  = next_addr;
            htrans_d = SEQ;
            state_d  = ST_BURST;
          end else begin
            htrans_d = IDLE;
            state_d  = ST_LAST;
          end
        end
      end
      ST_BURST: begin
        if (err_first) begin
          htrans_d = IDLE;
          state_d  = ST_ERR;
        end else if (HREADY) begin
          if (rd_capture) begin
            rd_data_d  = HRDATA[7:0];
            rd_valid_d = 1'b1;
          end
          wr_pop = hwrite_q;
          if (hwrite_q) hwdata_d = {{(DATAWIDTH-8){1'b0}}, wr_data};
          if (last_beat) begin
            htrans_d = IDLE;
            state_d  = ST_LAST;
          end else begin
            beat_d   = beat_q + 4'd1;
            haddr_d  = next_addr;
            htrans_d = SEQ;
          end
        end
      end
      ST_LAST: begin
        if (err_first) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          if (rd_capture) begin
            rd_data_d  = HRDATA[7:0];
            rd_valid_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      base_q     <= '0;
      htrans_q   <= IDLE;
      hwrite_q   <= 1'b0;
      hburst_q   <= SINGLE;
      hwdata_q   <= '0;
      beat_q     <= 4'd0;
      beats_q    <= 5'd1;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      base_q     <= base_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      beat_q     <= beat_d;
      beats_q    <= beats_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = DATATRANFER_SIZE;
  assign HBURST    = hburst_q;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_burst_master.sv
// ==================================================================
// tb_ahb_burst_master: scoreboard bench with a byte-memory AHB slave (rev 1.0)
// ==================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_burst_master;
  import Definitions::*;

  logic                 HCLK = 1'b0;
  logic                 HRESETn;
  logic                 cmd_valid, cmd_ready, cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  BType_t               cmd_burst;
  logic [4:0]           cmd_len;
  logic [7:0]           wr_data, rd_data;
  logic                 wr_pop, rd_valid, done, error;
  logic [ADDRWIDTH-1:0] HADDR;
  Trans_t               HTRANS;
  logic                 HWRITE, HMASTLOCK, HREADY;
  logic [2:0]           HSIZE;
  BType_t               HBURST;
  logic [3:0]           HPROT;
  logic [DATAWIDTH-1:0] HWDATA, HRDATA;
  Response_t            HRESP;

  ahb_burst_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues, filled by the stimulus, drained by the monitor.
  logic [31:0] q_addr[$];
  logic [1:0]  q_trans[$];
  logic [7:0]  q_rd[$];
  logic [7:0]  q_wd[$];
  logic [7:0]  wq[$];
  int          q_done[$];
  logic        q_derr[$];

  logic [7:0]  mem [256];
  int          cyc = 1000;
  int          err_cyc = 0, stall_from = 0, stall_len = 0;
  logic        err_2nd = 1'b0, pend = 1'b0, pend_wr = 1'b0, accept, cmd_acc;
  logic [7:0]  pend_addr = 8'h00, exp8;
  logic        prev_ready = 1'b1;
  Response_t   prev_resp = OKAY;
  logic [31:0] prev_haddr = 32'h0, prev_hwdata = 32'h0;
  logic [1:0]  prev_htrans = 2'b00;

  logic [7:0] wrap8_a [8] = '{8'h3D, 8'h3E, 8'h3F, 8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C};
  logic [7:0] wrap8_d [8] = '{8'h67, 8'h64, 8'h65, 8'h62, 8'h63, 8'h60, 8'h61, 8'h66};
  logic [7:0] wrap4_a [4] = '{8'h0E, 8'h0F, 8'h0C, 8'h0D};
  logic [7:0] wrap4_d [4] = '{8'h54, 8'h55, 8'h56, 8'h57};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pa(input logic [31:0] a, input logic [1:0] t);
    q_addr.push_back(a);
    q_trans.push_back(t);
  endtask

  task automatic pdone(input int c, input logic e);
    q_done.push_back(c);
    q_derr.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    $display("reset check: %s", tag);
    check("rst_htrans",    HTRANS,    IDLE);
    check("rst_haddr",     HADDR,     32'h0);
    check("rst_hwrite",    HWRITE,    0);
    check("rst_hburst",    HBURST,    SINGLE);
    check("rst_hwdata",    HWDATA,    32'h0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_pop",    wr_pop,    0);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_done",      done,      0);
    check("rst_error",     error,     0);
    check("rst_rd_data",   rd_data,   8'h00);
    check("hsize",         HSIZE,     3'b000);
    check("hprot",         HPROT,     4'b0011);
    check("hmastlock",     HMASTLOCK, 0);
  endtask

  task automatic flush();
    q_addr.delete(); q_trans.delete(); q_rd.delete(); q_wd.delete();
    wq.delete(); q_done.delete(); q_derr.delete();
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input BType_t b, input logic [4:0] len);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_burst = b; cmd_len = len;
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a, input BType_t b, input logic [4:0] len);
    int n;
    @(negedge HCLK);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge HCLK); n++; end
    drive_cmd(w, a, b, len);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    n = 0;
    while (q_done.size() != 0 && n < 60) begin @(negedge HCLK); n++; end
    #2;
    check("done_timeout",   q_done.size(), 0);
    check("addr_leftover",  q_addr.size(), 0);
    check("rd_leftover",    q_rd.size(),   0);
    check("wd_leftover",    q_wd.size(),   0);
    err_cyc = 0; stall_from = 0; stall_len = 0;
  endtask

  // Slave model plus monitor: drive slave inputs on the falling edge, sample just after.
  initial begin : slave_monitor
    forever begin
      @(negedge HCLK);
      if (err_cyc != 0 && cyc == err_cyc) begin
        HREADY = 1'b0; HRESP = ERROR; err_2nd = 1'b1;
      end else if (err_2nd) begin
        HREADY = 1'b1; HRESP = ERROR; err_2nd = 1'b0;
      end else if (stall_len != 0 && cyc >= stall_from && cyc < stall_from + stall_len) begin
        HREADY = 1'b0; HRESP = OKAY;
      end else begin
        HREADY = 1'b1; HRESP = OKAY;
      end
      HRDATA  = {24'hC3C3C3, (pend && !pend_wr) ? mem[pend_addr] : 8'hEE};
      wr_data = (wq.size() != 0) ? wq[0] : 8'h00;
      #1;
      if (!HRESETn) begin
        pend = 1'b0; err_2nd = 1'b0; prev_ready = 1'b1; prev_resp = OKAY; cyc = 1000;
      end else begin
        if (!prev_ready && prev_resp == OKAY) begin
          check("hold_haddr",  HADDR,  prev_haddr);
          check("hold_htrans", HTRANS, prev_htrans);
          check("hold_hwdata", HWDATA, prev_hwdata);
        end
        if (pend && HREADY) begin
          if (HRESP == OKAY && pend_wr) begin
            if (q_wd.size() == 0) check("wdata_unexpected", 1, 0);
            else begin
              exp8 = q_wd.pop_front();
              check("hwdata", HWDATA, {24'h0, exp8});
            end
            mem[pend_addr] = HWDATA[7:0];
          end
          pend = 1'b0;
        end
        accept = HREADY && (HTRANS == NONSEQ || HTRANS == SEQ);
        if (accept) begin
          if (q_addr.size() == 0) check("beat_unexpected", HADDR, 32'hFFFFFFFF);
          else begin
            check("haddr",  HADDR,  q_addr.pop_front());
            check("htrans", HTRANS, q_trans.pop_front());
          end
          pend = 1'b1; pend_addr = HADDR[7:0]; pend_wr = HWRITE;
        end
        if (wr_pop || (accept && HWRITE)) begin
          check("wr_pop", wr_pop, accept && HWRITE);
          if (wr_pop && wq.size() != 0) wq.delete(0);
        end
        if (rd_valid) begin
          if (q_rd.size() == 0) check("rd_unexpected", rd_data, 32'hFFFFFFFF);
          else check("rd_data", rd_data, q_rd.pop_front());
        end
        if (done) begin
          if (q_done.size() == 0) check("done_unexpected", 1, 0);
          else begin
            check("done_cycle", cyc, q_done.pop_front());
            check("done_error", error, q_derr.pop_front());
          end
          check("cmd_ready_at_done", cmd_ready, 1);
        end else if (error) begin
          check("error_without_done", error, 0);
        end
        cmd_acc     = cmd_valid && cmd_ready;
        prev_ready  = HREADY;
        prev_resp   = HRESP;
        prev_haddr  = HADDR;
        prev_htrans = HTRANS;
        prev_hwdata = HWDATA;
        cyc = cmd_acc ? 1 : cyc + 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_burst = SINGLE; cmd_len = 5'd0; HREADY = 1'b1; HRESP = OKAY;
    HRDATA = '0; wr_data = 8'h00;
    repeat (2) @(negedge HCLK);
    check_reset("power-on");
    #2 HRESETn = 1'b1;

    // Read SINGLE at 0x10: NONSEQ then IDLE, data and done in cycle 3.
    pa(32'h10, NONSEQ); q_rd.push_back(8'h4A); pdone(3, 0);
    run_cmd(1'b0, 32'h10, SINGLE, 5'd0);

    // Write INCR4 at 0x20 with 0xA1..0xA4.
    for (int i = 0; i < 4; i++) begin
      pa(32'h20 + 32'(i), (i == 0) ? NONSEQ : SEQ);
      wq.push_back(8'hA1 + 8'(i));
      q_wd.push_back(8'hA1 + 8'(i));
    end
    pdone(6, 0);
    run_cmd(1'b1, 32'h20, INCR4, 5'd0);

    // Read back INCR4 at 0x20.
    for (int i = 0; i < 4; i++) begin
      pa(32'h20 + 32'(i), (i == 0) ? NONSEQ : SEQ);
      q_rd.push_back(8'hA1 + 8'(i));
    end
    pdone(6, 0);
    run_cmd(1'b0, 32'h20, INCR4, 5'd0);

    // Read WRAP8 at 0x3D wraps inside 0x38..0x3F.
    for (int i = 0; i < 8; i++) begin
      pa({24'h0, wrap8_a[i]}, (i == 0) ? NONSEQ : SEQ);
      q_rd.push_back(wrap8_d[i]);
    end
    pdone(10, 0);
    run_cmd(1'b0, 32'h3D, WRAP8, 5'd0);

    // Write INCR len 5 at 0x40 with two wait states in cycles 2..3: done moves 7 -> 9.
    for (int i = 0; i < 5; i++) begin
      pa(32'h40 + 32'(i), (i == 0) ? NONSEQ : SEQ);
      wq.push_back(8'hB1 + 8'(i));
      q_wd.push_back(8'hB1 + 8'(i));
    end
    pdone(9, 0);
    stall_from = 2; stall_len = 2;
    run_cmd(1'b1, 32'h40, INCR, 5'd5);

    // INCR with len 0 behaves as a single beat; reads back the last byte written above.
    pa(32'h44, NONSEQ); q_rd.push_back(8'hB5); pdone(3, 0);
    run_cmd(1'b0, 32'h44, INCR, 5'd0);

    // ERROR on the first data phase of INCR8: only one address beat, done+error in cycle 4.
    pa(32'h50, NONSEQ); pdone(4, 1);
    err_cyc = 2;
    run_cmd(1'b0, 32'h50, INCR8, 5'd0);

    // Reset in cycle 3 of a WRAP16 read: outputs return to reset values at once.
    pa(32'h7A, NONSEQ); pa(32'h7B, SEQ); pa(32'h7C, SEQ); pa(32'h7D, SEQ);
    q_rd.push_back(8'h20); q_rd.push_back(8'h21);
    @(negedge HCLK);
    drive_cmd(1'b0, 32'h7A, WRAP16, 5'd0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    #3 HRESETn = 1'b0;
    #1 check_reset("mid-burst");
    check("beats_before_reset", q_addr.size(), 1);
    check("reads_before_reset", q_rd.size(), 1);
    flush();
    @(negedge HCLK);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;

    // Fresh WRAP4 read at 0x0E after reset.
    for (int i = 0; i < 4; i++) begin
      pa({24'h0, wrap4_a[i]}, (i == 0) ? NONSEQ : SEQ);
      q_rd.push_back(wrap4_d[i]);
    end
    pdone(6, 0);
    run_cmd(1'b0, 32'h0E, WRAP4, 5'd0);

    repeat (3) @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_burst_master.md
# ahb_burst_master

AHB-Lite bus master that turns single-cycle byte-burst commands into protocol-correct NONSEQ/SEQ address and data phases. It sits directly upstream of the memory-controller slave and drives its HSEL-qualified bus inputs. Bursts run with byte transfers and honour slave wait states and ERROR responses. Read data and write-data requests go through a simple local handshake.

## Interface
- ADDRWIDTH, 32, HADDR/cmd_addr width (Definitions package value)
- DATAWIDTH, 32, HWDATA/HRDATA width (Definitions package value)
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset; one clock, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDRWIDTH  first beat address
- cmd_burst  in  BType_t  SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
- cmd_len  in  5  beat count for INCR only (1..16; 0 treated as 1)
- wr_data  in  8  byte for the write beat being issued
- wr_pop  out  1  pulse: wr_data consumed this edge
- rd_data  out  8  read byte (registered)
- rd_valid  out  1  pulse: rd_data valid
- done  out  1  pulse: burst finished
- error  out  1  pulse with done when burst ended by ERROR
- HADDR  out  ADDRWIDTH; HTRANS  out  Trans_t; HWRITE  out  1; HSIZE  out  3 (fixed 3'b000); HBURST  out  BType_t; HPROT  out  4 (fixed 4'b0011); HMASTLOCK  out  1 (fixed 0); HWDATA  out  DATAWIDTH
- HREADY  in  1; HRESP  in  Response_t; HRDATA  in  DATAWIDTH

## Operation
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HBURST=SINGLE, HWDATA=0, cmd_ready=1, wr_pop/rd_valid/done/error=0, rd_data=0. Reset mid-burst abandons the burst immediately. There is no completion pulse.
- States:
  - IDLE: accept command, go to ADDR.
  - ADDR: NONSEQ on bus. When HREADY, go to BURST if beats>1, else LAST.
  - BURST: SEQ beats. When HREADY on the final address, go to LAST.
  - LAST: final data phase, HTRANS=IDLE. When HREADY, go to IDLE with done.
  - ERR: HTRANS=IDLE, wait for HREADY, then go to IDLE with done+error.
- Beats: SINGLE=1; INCRx/WRAPx=x; INCR=cmd_len.
- Address step is +1 per beat (byte size), ADDRWIDTH-bit wrap-around.
  - WRAP4/8/16 hold the upper bits and wrap the low 2/3/4 bits modulo beats.
  - Example: WRAP4 from 0x0E gives 0x0E,0x0F,0x0C,0x0D.
- Address and control outputs change only on edges where HREADY=1, except on ERROR.
- Write beats:
  - wr_pop pulses on each edge where a write address phase is accepted (HREADY=1).
  - wr_data is registered into HWDATA[7:0] (upper bits 0) for the following data phase. HWDATA holds while HREADY=0.
- Read beats: on each edge completing a read data phase (HREADY=1, HRESP=OKAY), rd_data<=HRDATA[7:0] and rd_valid pulses next cycle.
- ERROR: on the first ERROR cycle (HRESP=ERROR, HREADY=0), the next cycle drives HTRANS=IDLE and enters ERR. No further beats, rd_valid or wr_pop are issued.
- 1 KB boundary checking is the commander's responsibility. It is not checked here.

## Timing
- Command accepted at edge 0 puts NONSEQ on the bus in cycle 1 (registered outputs, no combinational path from cmd to bus).
- With zero wait states, an N-beat burst runs:
  - address phases in cycles 1..N
  - data phases in cycles 2..N+1
  - done, cmd_ready=1 and the last rd_valid in cycle N+2
- Each HREADY=0 cycle stretches the schedule by exactly one cycle.
- Back-to-back commands get at least one IDLE bus cycle between bursts.
- HTRANS never BUSY.

## Structure
- Trans_t, BType_t, Response_t, ADDRWIDTH, DATAWIDTH and DATATRANFER_SIZE belong in Definitions. Add the state enum Mst_State_t there.
- One natural sub-module, ahb_addr_gen: combinational next-address (base, beat index, burst type) for incrementing and wrap arithmetic.

## Test plan
- Read SINGLE at 0x10, HREADY=1 -> HTRANS NONSEQ,IDLE; rd_data = memory byte at 0x10 in cycle 3; done cycle 3.
- Write INCR4 at 0x20 with data 0xA1..0xA4 -> HADDR 0x20..0x23, SEQ x3, 4 wr_pop, memory reads back 0xA1..0xA4.
- Read WRAP8 at 0x3D -> HADDR 0x3D,3E,3F,38,39,3A,3B,3C, 8 rd_valid.
- INCR cmd_len=5 with HREADY low 2 cycles on beat 2 -> HADDR/HWDATA held, done at cycle 9.
- HRESP=ERROR on beat 1 of INCR8 -> HTRANS IDLE next cycle, done+error pulse, no further beats.
- HRESETn low mid WRAP16 -> all outputs at reset values immediately, next command starts cleanly.
